// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider with per-channel enable, duty
// control and reconfiguration that takes effect only at period boundaries.
module clk_div_bank #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CH_W     = 2,
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned DEF_DIV  = 1,
  parameter int unsigned DEF_HIGH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_high,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] running,
  output logic [NUM_CH-1:0] cfg_pend
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q [NUM_CH];
  state_t           state_d [NUM_CH];
  logic [DIV_W-1:0] cnt_q   [NUM_CH];
  logic [DIV_W-1:0] cnt_d   [NUM_CH];
  logic [DIV_W-1:0] div_q   [NUM_CH];
  logic [DIV_W-1:0] div_d   [NUM_CH];
  logic [DIV_W-1:0] high_q  [NUM_CH];
  logic [DIV_W-1:0] high_d  [NUM_CH];
  logic [DIV_W-1:0] pdiv_q  [NUM_CH];
  logic [DIV_W-1:0] pdiv_d  [NUM_CH];
  logic [DIV_W-1:0] phigh_q [NUM_CH];
  logic [DIV_W-1:0] phigh_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] clk_d, tick_d;
  logic [NUM_CH-1:0] hit, wrap;

  // State, counter, config and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        div_q[i]   <= DIV_W'(DEF_DIV);
        high_q[i]  <= DIV_W'(DEF_HIGH);
        pdiv_q[i]  <= DIV_W'(DEF_DIV);
        phigh_q[i] <= DIV_W'(DEF_HIGH);
      end
      pend_q  <= '0;
      clk_out <= '0;
      tick    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        div_q[i]   <= div_d[i];
        high_q[i]  <= high_d[i];
        pdiv_q[i]  <= pdiv_d[i];
        phigh_q[i] <= phigh_d[i];
      end
      pend_q  <= pend_d;
      clk_out <= clk_d;
      tick    <= tick_d;
    end
  end

  // Next state per channel; outputs are precomputed from next-state values
  always_comb begin
    pend_d = pend_q;
    clk_d  = '0;
    tick_d = '0;
    hit    = '0;
    wrap   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      div_d[i]   = div_q[i];
      high_d[i]  = high_q[i];
      pdiv_d[i]  = pdiv_q[i];
      phigh_d[i] = phigh_q[i];
      hit[i]  = cfg_we && (cfg_ch == CH_W'(i));
      wrap[i] = (state_q[i] == RUN) && (cnt_q[i] == div_q[i]);

      if (state_q[i] == IDLE) begin
        if (pend_q[i]) begin
          div_d[i]  = pdiv_q[i];
          high_d[i] = phigh_q[i];
          pend_d[i] = 1'b0;
        end
        cnt_d[i] = '0;
        if (en[i]) state_d[i] = RUN;
      end else if (wrap[i]) begin
        // A write landing on the wrap edge wins over older pending values
        if (hit[i]) begin
          div_d[i]  = cfg_div;
          high_d[i] = cfg_high;
        end else if (pend_q[i]) begin
          div_d[i]  = pdiv_q[i];
          high_d[i] = phigh_q[i];
        end
        pend_d[i] = 1'b0;
        cnt_d[i]  = '0;
        if (!en[i]) state_d[i] = IDLE;
      end else begin
        cnt_d[i] = cnt_q[i] + DIV_W'(1);
      end

      if (hit[i] && !wrap[i]) begin
        pdiv_d[i]  = cfg_div;
        phigh_d[i] = cfg_high;
        pend_d[i]  = 1'b1;
      end

      // cnt never exceeds div, so cnt < high already implies the min(H,P) clamp
      clk_d[i]  = (state_d[i] == RUN) && (cnt_d[i] < high_d[i]);
      tick_d[i] = (state_d[i] == RUN) && (cnt_d[i] == div_d[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) running[i] = (state_q[i] == RUN);
  end

  assign cfg_pend = pend_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: directed vector table, hand-written
// corner sequences and randomized traffic against a cycle-level reference model.
module tb_clk_div_bank;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 3;
  localparam int unsigned DIV_W  = 8;

  logic              clk;
  logic              rst_n;
  logic [NUM_CH-1:0] en;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic [DIV_W-1:0]  cfg_high;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] running;
  logic [NUM_CH-1:0] cfg_pend;

  clk_div_bank #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .DIV_W(DIV_W), .DEF_DIV(1), .DEF_HIGH(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_high(cfg_high), .clk_out(clk_out), .tick(tick),
    .running(running), .cfg_pend(cfg_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: period P = div+1 cycles, high for the first min(H,P) cycles
  int m_div [NUM_CH];
  int m_high[NUM_CH];
  int p_div [NUM_CH];
  int p_high[NUM_CH];
  int m_cnt [NUM_CH];
  bit m_run [NUM_CH];
  bit m_pend[NUM_CH];

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_div[c] = 1; m_high[c] = 1; p_div[c] = 1; p_high[c] = 1;
      m_cnt[c] = 0; m_run[c] = 0; m_pend[c] = 0;
    end
  endtask

  task automatic model_update();
    for (int c = 0; c < NUM_CH; c++) begin
      bit hit;
      bit period_end;
      hit = cfg_we && (int'(cfg_ch) == c);
      period_end = 0;
      if (!m_run[c]) begin
        if (m_pend[c]) begin
          m_div[c] = p_div[c]; m_high[c] = p_high[c]; m_pend[c] = 0;
        end
        m_cnt[c] = 0;
        m_run[c] = en[c];
      end else if (m_cnt[c] == m_div[c]) begin
        period_end = 1;
        if (hit) begin
          m_div[c] = int'(cfg_div); m_high[c] = int'(cfg_high);
        end else if (m_pend[c]) begin
          m_div[c] = p_div[c]; m_high[c] = p_high[c];
        end
        m_pend[c] = 0;
        m_cnt[c]  = 0;
        m_run[c]  = en[c];
      end else begin
        m_cnt[c]++;
      end
      if (hit && !period_end) begin
        p_div[c] = int'(cfg_div); p_high[c] = int'(cfg_high); m_pend[c] = 1;
      end
    end
  endtask

  task automatic check_model();
    logic [NUM_CH-1:0] e_clk, e_tick, e_run, e_pend;
    for (int c = 0; c < NUM_CH; c++) begin
      int heff;
      heff = (m_high[c] < m_div[c] + 1) ? m_high[c] : m_div[c] + 1;
      e_clk[c]  = m_run[c] && (m_cnt[c] < heff);
      e_tick[c] = m_run[c] && (m_cnt[c] == m_div[c]);
      e_run[c]  = m_run[c];
      e_pend[c] = m_pend[c];
    end
    check("model_clk_out",  32'(clk_out),  32'(e_clk));
    check("model_tick",     32'(tick),     32'(e_tick));
    check("model_running",  32'(running),  32'(e_run));
    check("model_cfg_pend", 32'(cfg_pend), 32'(e_pend));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(input logic [NUM_CH-1:0] e, input logic we, input int ch,
                       input int dv, input int hi);
    en = e; cfg_we = we; cfg_ch = CH_W'(ch); cfg_div = DIV_W'(dv); cfg_high = DIV_W'(hi);
  endtask

  typedef struct {
    logic [3:0] en;
    logic       we;
    logic [2:0] ch;
    logic [7:0] dv;
    logic [7:0] hi;
    logic [3:0] e_clk;
    logic [3:0] e_tick;
    logic [3:0] e_run;
    logic [3:0] e_pend;
  } vec_t;

  vec_t tbl[22];

  initial begin
    // Default ch0, program ch1 4/2, reconfig mid-period, then reconfig on the wrap edge
    tbl[0]  = '{4'b0001, 1'b0, 3'd0, 8'd0, 8'd0, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
    tbl[1]  = '{4'b0001, 1'b0, 3'd0, 8'd0, 8'd0, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
    tbl[2]  = '{4'b0001, 1'b1, 3'd1, 8'd4, 8'd2, 4'b0001, 4'b0000, 4'b0001, 4'b0010};
    tbl[3]  = '{4'b0001, 1'b0, 3'd0, 8'd0, 8'd0, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
    tbl[4]  = '{4'b0011, 1'b0, 3'd0, 8'd0, 8'd0, 4'b0011, 4'b0000, 4'b0011, 4'b0000};
    tbl[5]  = '{4'b0011, 1'b0, 3'd0, 8'd0, 8'd0, 4'b0010, 4'b0001, 4'b0011, 4'b0000};
    tbl[6]  = '{4'b0011, 1'b0, 3'd0, 8'd0, 8'd0, 4'b0001, 4'b0000, 4'b0011, 4'b0000};
    tbl[7]  = '{4'b0011, 1'b0, 3'd0, 8'd0, 8'd0, 4'b0000, 4'b0001, 4'b0011, 4'b0000};
    tbl[8]  = '{4'b0011, 1'b0, 3'd0, 8'd0, 8'd0, 4'b0001, 4'b0010, 4'b0011, 4'b0000};
    tbl[9]  = '{4'b0011, 1'b0, 3'd0, 8'd0, 8'd0, 4'b0010, 4'b0001, 4'b0011, 4'b0000};
    tbl[10] = '{4'b0011, 1'b0, 3'd0, 8'd0, 8'd0, 4'b0011, 4'b0000, 4'b0011, 4'b0000};
    tbl[11] = '{4'b0011, 1'b1, 3'd1, 8'd2, 8'd1, 4'b0000, 4'b0001, 4'b0011, 4'b0010};
    tbl[12] = '{4'b0011, 1'b0, 3'd0, 8'd0, 8'd0, 4'b0001, 4'b0000, 4'b0011, 4'b0010};
    tbl[13] = '{4'b0011, 1'b0, 3'd0, 8'd0, 8'd0, 4'b0000, 4'b0011, 4'b0011, 4'b0010};
    tbl[14] = '{4'b0011, 1'b0, 3'd0, 8'd0, 8'd0, 4'b0011, 4'b0000, 4'b0011, 4'b0000};
    tbl[15] = '{4'b0011, 1'b0, 3'd0, 8'd0, 8'd0, 4'b0000, 4'b0001, 4'b0011, 4'b0000};
    tbl[16] = '{4'b0011, 1'b0, 3'd0, 8'd0, 8'd0, 4'b0001, 4'b0010, 4'b0011, 4'b0000};
    tbl[17] = '{4'b0011, 1'b0, 3'd0, 8'd0, 8'd0, 4'b0010, 4'b0001, 4'b0011, 4'b0000};
    tbl[18] = '{4'b0011, 1'b0, 3'd0, 8'd0, 8'd0, 4'b0001, 4'b0000, 4'b0011, 4'b0000};
    tbl[19] = '{4'b0011, 1'b0, 3'd0, 8'd0, 8'd0, 4'b0000, 4'b0011, 4'b0011, 4'b0000};
    tbl[20] = '{4'b0011, 1'b1, 3'd1, 8'd0, 8'd1, 4'b0011, 4'b0010, 4'b0011, 4'b0000};
    tbl[21] = '{4'b0011, 1'b0, 3'd0, 8'd0, 8'd0, 4'b0010, 4'b0011, 4'b0011, 4'b0000};

    model_reset();
    rst_n = 1'b0;
    drive('0, 1'b0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset_clk_out",  32'(clk_out),  32'd0);
    check("reset_tick",     32'(tick),     32'd0);
    check("reset_running",  32'(running),  32'd0);
    check("reset_cfg_pend", 32'(cfg_pend), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].en, tbl[i].we, int'(tbl[i].ch), int'(tbl[i].dv), int'(tbl[i].hi));
      step();
      check($sformatf("vec%0d_clk_out", i),  32'(clk_out),  32'(tbl[i].e_clk));
      check($sformatf("vec%0d_tick", i),     32'(tick),     32'(tbl[i].e_tick));
      check($sformatf("vec%0d_running", i),  32'(running),  32'(tbl[i].e_run));
      check($sformatf("vec%0d_cfg_pend", i), 32'(cfg_pend), 32'(tbl[i].e_pend));
    end

    // Stop mid-period on ch2 (P=6, H=3): period completes, then IDLE
    drive(4'b0011, 1'b1, 2, 5, 3); step();
    drive(4'b0111, 1'b0, 0, 0, 0); step(); step(); step();
    drive(4'b0011, 1'b0, 0, 0, 0); step(); step(); step();
    check("stop_still_running", 32'(running[2]), 32'd1);
    step();
    check("stop_running_low", 32'(running[2]), 32'd0);
    check("stop_clk_low",     32'(clk_out[2]), 32'd0);

    // Brief en drop before the wrap keeps the waveform continuous
    drive(4'b0111, 1'b0, 0, 0, 0); step(); step();
    drive(4'b0011, 1'b0, 0, 0, 0); step();
    drive(4'b0111, 1'b0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step();
    check("restart_no_gap", 32'(running[2]), 32'd1);

    // Edge values: P=1/H=1, H clamp above P, H=0
    drive(4'b1011, 1'b1, 0, 0, 1);   step();
    drive(4'b1011, 1'b1, 1, 3, 200); step();
    drive(4'b1011, 1'b1, 3, 2, 0);   step();
    drive(4'b1011, 1'b0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step();
    for (int i = 0; i < 6; i++) begin
      step();
      check("edge_p1_clk",    32'(clk_out[0]), 32'd1);
      check("edge_p1_tick",   32'(tick[0]),    32'd1);
      check("edge_clamp_clk", 32'(clk_out[1]), 32'd1);
      check("edge_h0_clk",    32'(clk_out[3]), 32'd0);
    end

    // Write to a channel index beyond NUM_CH is ignored
    drive(4'b1011, 1'b1, 4, 9, 9); step();
    check("bad_ch_pend", 32'(cfg_pend), 32'd0);
    drive(4'b1011, 1'b0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step();

    // Randomized traffic checked against the model each cycle
    for (int i = 0; i < 2000; i++) begin
      logic [NUM_CH-1:0] e;
      e = en;
      for (int c = 0; c < NUM_CH; c++) if ($urandom_range(0, 7) == 0) e[c] = ~e[c];
      if ($urandom_range(0, 3) == 0)
        drive(e, 1'b1, int'($urandom_range(0, 5)), int'($urandom_range(0, 6)),
              ($urandom_range(0, 9) == 0) ? 200 : int'($urandom_range(0, 8)));
      else
        drive(e, 1'b0, 0, 0, 0);
      step();
    end

    // Async reset with everything running, then defaults after release
    drive(4'b1111, 1'b0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step();
    check("pre_reset_all_running", 32'(running), 32'hf);
    @(posedge clk);
    model_update();
    #2 rst_n = 1'b0;
    #1;
    check("async_clk_out",  32'(clk_out),  32'd0);
    check("async_tick",     32'(tick),     32'd0);
    check("async_running",  32'(running),  32'd0);
    check("async_cfg_pend", 32'(cfg_pend), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0001, 1'b0, 0, 0, 0);
    step();
    check("post_reset_clk0_first", 32'(clk_out[0]), 32'd1);
    step();
    check("post_reset_tick0", 32'(tick[0]), 32'd1);
    for (int i = 0; i < 4; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
